// File: rtl/dsp_mute_seq.sv
// Pop-free enable/bypass sequencer: owns DSP core reset, bypass select and a linearly ramped gain.
// Optional RAMP_DN stall timeout enabled by defining DSP_SEQ_TIMEOUT_EN.
module dsp_mute_seq #(
  parameter logic [31:0] STEP           = 32'h0010_0000,
  parameter int unsigned WARM_SAMPLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dsp_en,
  input  logic        bypass_req,
  input  logic        sample_tick,
  input  logic [31:0] target_gain,
  output logic [31:0] gain_out,
  output logic        core_rst,
  output logic        bypass_sel,
  output logic        busy,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StStart  = 2'd1,
    StRun    = 2'd2,
    StRampDn = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] gain_q, gain_d;
  logic [31:0] warm_q, warm_d;
  logic        bypass_sel_q, bypass_sel_d;
  logic        busy_q, busy_d;
  logic        core_rst_q;
  logic        timeout_hit;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  // Up step in 33 bits so the sum can never wrap before the clamp.
  logic [32:0] up_sum;
  logic [31:0] up_gain, dn_gain, track_gain, mute_gain;
  logic        warm_done;

  always_comb begin
    up_sum  = {1'b0, gain_q} + {1'b0, STEP};
    up_gain = (up_sum >= {1'b0, target_gain}) ? target_gain : up_sum[31:0];
    dn_gain = ((gain_q - target_gain) <= STEP) ? target_gain : gain_q - STEP;
    if (gain_q < target_gain) begin
      track_gain = up_gain;
    end else if (gain_q > target_gain) begin
      track_gain = dn_gain;
    end else begin
      track_gain = gain_q;
    end
    mute_gain = (gain_q <= STEP) ? 32'd0 : gain_q - STEP;
    warm_done = (WARM_SAMPLES == 0) ||
                (sample_tick && ((warm_q + 32'd1) >= 32'(WARM_SAMPLES)));
  end

`ifdef DSP_SEQ_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == StRampDn && !sample_tick) begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == StRampDn) && !sample_tick &&
                       (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    gain_d       = gain_q;
    warm_d       = warm_q;
    bypass_sel_d = bypass_sel_q;
    unique case (state_q)
      StOff: begin
        gain_d       = '0;
        warm_d       = '0;
        bypass_sel_d = bypass_req;
        if (dsp_en && !bypass_req) state_d = StStart;
      end
      StStart: begin
        gain_d = '0;
        if (!dsp_en || bypass_req) begin
          state_d = StOff;
        end else if (warm_done) begin
          state_d = StRun;
        end else if (sample_tick) begin
          warm_d = warm_q + 32'd1;
        end
      end
      StRun: begin
        // A tick coinciding with the exit condition is still a RUN step.
        if (sample_tick) gain_d = track_gain;
        if (!dsp_en || (bypass_req != bypass_sel_q)) state_d = StRampDn;
      end
      StRampDn: begin
        // Re-enable is ignored here: the mute always completes.
        if (timeout_hit) begin
          gain_d  = '0;
          state_d = StOff;
        end else begin
          if (sample_tick) gain_d = mute_gain;
          if (gain_q == '0) state_d = StOff;
        end
      end
      default: state_d = StOff;
    endcase
    busy_d = (state_d == StStart) || (state_d == StRampDn) ||
             ((state_d == StRun) && (gain_d != target_gain));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StOff;
      gain_q       <= '0;
      warm_q       <= '0;
      bypass_sel_q <= 1'b0;
      busy_q       <= 1'b0;
      core_rst_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      warm_q       <= warm_d;
      bypass_sel_q <= bypass_sel_d;
      busy_q       <= busy_d;
      // Lags the state by one clock so release/assert brackets START and OFF.
      core_rst_q   <= (state_q == StOff);
    end
  end

  assign gain_out   = gain_q;
  assign core_rst   = core_rst_q;
  assign bypass_sel = bypass_sel_q;
  assign busy       = busy_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dsp_mute_seq.sv
// Directed, table-driven bench for dsp_mute_seq (STEP=0x100, WARM_SAMPLES=2) plus a wide-STEP
// instance for the 32-bit wrap corner.
module tb_dsp_mute_seq;

  logic        clk;
  logic        rst_n;
  logic        dsp_en, bypass_req, sample_tick;
  logic [31:0] target_gain;
  logic [31:0] gain_out;
  logic        core_rst, bypass_sel, busy;
  logic [1:0]  state;

  logic        big_en, big_byp, big_tick;
  logic [31:0] big_tgt, big_gain;
  logic        big_core_rst, big_bypass_sel, big_busy;
  logic [1:0]  big_state;

  int n_tests = 0;
  int n_fail  = 0;

  dsp_mute_seq #(
    .STEP          (32'h0000_0100),
    .WARM_SAMPLES  (2),
    .TIMEOUT_CYCLES(4096)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dsp_en     (dsp_en),
    .bypass_req (bypass_req),
    .sample_tick(sample_tick),
    .target_gain(target_gain),
    .gain_out   (gain_out),
    .core_rst   (core_rst),
    .bypass_sel (bypass_sel),
    .busy       (busy),
    .state      (state)
  );

  dsp_mute_seq #(
    .STEP          (32'h4000_0000),
    .WARM_SAMPLES  (1),
    .TIMEOUT_CYCLES(4096)
  ) u_big (
    .clk        (clk),
    .rst_n      (rst_n),
    .dsp_en     (big_en),
    .bypass_req (big_byp),
    .sample_tick(big_tick),
    .target_gain(big_tgt),
    .gain_out   (big_gain),
    .core_rst   (big_core_rst),
    .bypass_sel (big_bypass_sel),
    .busy       (big_busy),
    .state      (big_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic        byp;
    logic        tick;
    logic [31:0] tgt;
    logic [31:0] gain;
    logic [1:0]  st;
    logic        crst;
    logic        bsel;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic byp, input logic tick, input logic [31:0] tgt,
                     input logic [31:0] gain, input logic [1:0] st, input logic crst,
                     input logic bsel, input logic bsy);
    vec_t v;
    v.en = en; v.byp = byp; v.tick = tick; v.tgt = tgt;
    v.gain = gain; v.st = st; v.crst = crst; v.bsel = bsel; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic byp, input logic tick, input logic [31:0] tgt);
    dsp_en      = en;
    bypass_req  = byp;
    sample_tick = tick;
    target_gain = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic big_step(input logic tick, input logic [31:0] tgt, input logic [31:0] exp,
                          input string name);
    big_tick = tick;
    big_tgt  = tgt;
    @(posedge clk);
    #1;
    chk(name, big_gain, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".gain"}, gain_out, 32'h0);
    chk({tag, ".core_rst"}, 32'(core_rst), 32'h1);
    chk({tag, ".bypass_sel"}, 32'(bypass_sel), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".state"}, 32'(state), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    dsp_en = 1'b0; bypass_req = 1'b0; sample_tick = 1'b0; target_gain = 32'h400;
    big_en = 1'b0; big_byp = 1'b0; big_tick = 1'b0; big_tgt = 32'h0;

    // Tests 1-4: enable ramp, disable mute, bypass mute, retarget with clamp.
    add(1,0,0,32'h400, 32'h000,1,1,0,1);
    add(1,0,0,32'h400, 32'h000,1,0,0,1);
    add(1,0,1,32'h400, 32'h000,1,0,0,1);
    add(1,0,1,32'h400, 32'h000,2,0,0,1);
    add(1,0,1,32'h400, 32'h100,2,0,0,1);
    add(1,0,1,32'h400, 32'h200,2,0,0,1);
    add(1,0,0,32'h400, 32'h200,2,0,0,1);
    add(1,0,1,32'h400, 32'h300,2,0,0,1);
    add(1,0,1,32'h400, 32'h400,2,0,0,0);
    add(1,0,1,32'h400, 32'h400,2,0,0,0);
    add(0,0,0,32'h400, 32'h400,3,0,0,1);
    add(0,0,1,32'h400, 32'h300,3,0,0,1);
    add(0,0,1,32'h400, 32'h200,3,0,0,1);
    add(0,0,1,32'h400, 32'h100,3,0,0,1);
    add(0,0,1,32'h400, 32'h000,3,0,0,1);
    add(0,0,0,32'h400, 32'h000,0,0,0,0);
    add(0,0,0,32'h400, 32'h000,0,1,0,0);
    add(1,0,0,32'h400, 32'h000,1,1,0,1);
    add(1,0,1,32'h400, 32'h000,1,0,0,1);
    add(1,0,1,32'h400, 32'h000,2,0,0,1);
    add(1,0,1,32'h400, 32'h100,2,0,0,1);
    add(1,0,1,32'h400, 32'h200,2,0,0,1);
    add(1,0,1,32'h400, 32'h300,2,0,0,1);
    add(1,0,1,32'h400, 32'h400,2,0,0,0);
    add(1,1,0,32'h400, 32'h400,3,0,0,1);
    add(1,1,1,32'h400, 32'h300,3,0,0,1);
    add(1,1,1,32'h400, 32'h200,3,0,0,1);
    add(1,1,1,32'h400, 32'h100,3,0,0,1);
    add(1,1,1,32'h400, 32'h000,3,0,0,1);
    add(1,1,0,32'h400, 32'h000,0,0,0,0);
    add(1,1,0,32'h400, 32'h000,0,1,1,0);
    add(1,1,1,32'h400, 32'h000,0,1,1,0);
    add(1,0,0,32'h400, 32'h000,1,1,0,1);
    add(1,0,1,32'h400, 32'h000,1,0,0,1);
    add(1,0,1,32'h400, 32'h000,2,0,0,1);
    add(1,0,1,32'h400, 32'h100,2,0,0,1);
    add(1,0,1,32'h400, 32'h200,2,0,0,1);
    add(1,0,1,32'h400, 32'h300,2,0,0,1);
    add(1,0,1,32'h400, 32'h400,2,0,0,0);
    add(1,0,0,32'h250, 32'h400,2,0,0,1);
    add(1,0,1,32'h250, 32'h300,2,0,0,1);
    add(1,0,1,32'h250, 32'h250,2,0,0,0);

    #12;
    chk_reset("reset");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].byp, vecs[i].tick, vecs[i].tgt);
      chk($sformatf("v%0d.gain", i), gain_out, vecs[i].gain);
      chk($sformatf("v%0d.state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d.core_rst", i), 32'(core_rst), 32'(vecs[i].crst));
      chk($sformatf("v%0d.bypass_sel", i), 32'(bypass_sel), 32'(vecs[i].bsel));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
    end

    // Near-full-scale ramp on the wide-STEP instance: the up step must clamp, not wrap.
    big_en = 1'b1;
    big_step(1'b0, 32'hFFFF_FF00, 32'h0, "big.start");
    chk("big.state_start", 32'(big_state), 32'h1);
    big_step(1'b1, 32'hFFFF_FF00, 32'h0, "big.warm");
    chk("big.state_run", 32'(big_state), 32'h2);
    big_step(1'b1, 32'hFFFF_FF00, 32'h4000_0000, "big.up1");
    big_step(1'b1, 32'hFFFF_FF00, 32'h8000_0000, "big.up2");
    big_step(1'b1, 32'hFFFF_FF00, 32'hC000_0000, "big.up3");
    big_step(1'b1, 32'hFFFF_FF00, 32'hFFFF_FF00, "big.clamp_ff00");
    big_step(1'b1, 32'hFFFF_FF80, 32'hFFFF_FF80, "big.clamp_ff80");
    big_step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "big.no_wrap");
    big_step(1'b1, 32'h0000_0010, 32'hBFFF_FFFF, "big.reverse");
    big_tick = 1'b0;
    big_en   = 1'b0;

    // Test 5: tick coincident with dsp_en falling is a RUN step; then ticks stall in RAMP_DN.
    drive(1, 0, 1, 32'h400);
    chk("t5.run_up", gain_out, 32'h350);
    drive(0, 0, 1, 32'h400);
    chk("t5.last_run_step", gain_out, 32'h400);
    chk("t5.enter_ramp_dn", 32'(state), 32'h3);
    drive(0, 0, 1, 32'h400);
    chk("t5.first_dn", gain_out, 32'h300);
`ifdef DSP_SEQ_TIMEOUT_EN
    repeat (4095) drive(1, 0, 0, 32'h400);
    chk("t5.pre_timeout_state", 32'(state), 32'h3);
    chk("t5.pre_timeout_gain", gain_out, 32'h300);
    drive(1, 0, 0, 32'h400);
    chk("t5.timeout_state", 32'(state), 32'h0);
    chk("t5.timeout_gain", gain_out, 32'h0);
`else
    repeat (4200) drive(1, 0, 0, 32'h400);
    chk("t5.stall_state", 32'(state), 32'h3);
    chk("t5.stall_gain", gain_out, 32'h300);
`endif
    repeat (6) drive(0, 0, 1, 32'h400);
    chk("t5.off_state", 32'(state), 32'h0);
    chk("t5.off_gain", gain_out, 32'h0);
    chk("t5.off_core_rst", 32'(core_rst), 32'h1);
    chk("t5.off_busy", 32'(busy), 32'h0);

    // Test 6: asynchronous reset mid ramp-up, then restart with dsp_en held.
    drive(1, 0, 0, 32'h400);
    drive(1, 0, 1, 32'h400);
    drive(1, 0, 1, 32'h400);
    drive(1, 0, 1, 32'h400);
    drive(1, 0, 1, 32'h400);
    chk("t6.pre_reset_gain", gain_out, 32'h200);
    sample_tick = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk_reset("t6.async");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6.restart_state", 32'(state), 32'h1);
    chk("t6.restart_core_rst", 32'(core_rst), 32'h1);
    chk("t6.restart_busy", 32'(busy), 32'h1);
    drive(1, 0, 0, 32'h400);
    chk("t6.core_rst_release", 32'(core_rst), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
